// File: rtl/mem_port_arbiter_if.sv
// Requester/memory bundle for mem_port_arbiter.
// The arbiter is the slave side; the system (requesters plus memory) is the master side.
interface mem_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 16,
  parameter int DW      = 32
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_lock;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rvalid;
  logic [DW-1:0]         rdata;
  logic                  mem_clk;
  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic [DW-1:0]         mem_write_data;
  logic [DW-1:0]         mem_read_data;

  modport master (
    output req, req_we, req_addr, req_wdata, req_lock, mem_read_data,
    input  gnt, rvalid, rdata, mem_clk, mem_we, mem_addr, mem_write_data
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, req_lock, mem_read_data,
    output gnt, rvalid, rdata, mem_clk, mem_we, mem_addr, mem_write_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ requesters, 2-cycle read return.
// Define BURST_LOCK_EN to let a requester keep priority for up to MAX_LOCK locked accesses.
module mem_port_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 16
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      cand_s;
  logic [PW-1:0]      gnt_idx_s;
  logic               gnt_any_s;
  logic               accept_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic               mem_we_q, mem_we_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic [DW-1:0]      mem_wdata_q, mem_wdata_d;
  logic               tag_vld_q, tag_vld_d;
  logic [PW-1:0]      tag_q, tag_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    logic [PW-1:0] res;
    if (int'(idx) >= NUM_REQ - 1) begin
      res = {PW{1'b0}};
    end else begin
      res = idx + PW'(1'b1);
    end
    return res;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Rotating-priority scan starting at ptr_q; first requester found wins.
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_idx_s = {PW{1'b0}};
    cand_s    = {PW{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s    = PW'((int'(ptr_q) + k) % NUM_REQ);
      gnt_idx_s = (bus.req[cand_s] && !gnt_any_s) ? cand_s : gnt_idx_s;
      gnt_any_s = gnt_any_s | bus.req[cand_s];
    end
    accept_s = gnt_any_s && !reset;
    gnt_s    = accept_s ? onehot(gnt_idx_s) : {NUM_REQ{1'b0}};
  end

`ifdef BURST_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
`else
  localparam int unused_max_lock = MAX_LOCK;
  logic          unused_lock_s;
  assign unused_lock_s = ^bus.req_lock;
`endif

  // Next-state: capture the accepted access, advance priority, shift the read tag.
  always_comb begin
    ptr_d       = ptr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tag_vld_d   = 1'b0;
    tag_d       = tag_q;
`ifdef BURST_LOCK_EN
    lock_cnt_d  = lock_cnt_q;
`endif
    if (tag_vld_q) begin
      rvalid_d = onehot(tag_q);
    end else begin
      rvalid_d = {NUM_REQ{1'b0}};
    end
    if (accept_s) begin
      mem_we_d    = bus.req_we[gnt_idx_s];
      mem_addr_d  = bus.req_addr[int'(gnt_idx_s)*AW +: AW];
      mem_wdata_d = bus.req_wdata[int'(gnt_idx_s)*DW +: DW];
      tag_vld_d   = !bus.req_we[gnt_idx_s];
      tag_d       = gnt_idx_s;
`ifdef BURST_LOCK_EN
      if (bus.req_lock[gnt_idx_s] && (lock_cnt_q < CW'(MAX_LOCK - 1))) begin
        ptr_d      = gnt_idx_s;
        lock_cnt_d = lock_cnt_q + CW'(1'b1);
      end else begin
        ptr_d      = next_idx(gnt_idx_s);
        lock_cnt_d = {CW{1'b0}};
      end
`else
      ptr_d       = next_idx(gnt_idx_s);
`endif
    end else begin
`ifdef BURST_LOCK_EN
      // An idle cycle while locked releases the lock to the next requester.
      if (lock_cnt_q != {CW{1'b0}}) begin
        ptr_d      = next_idx(ptr_q);
        lock_cnt_d = {CW{1'b0}};
      end else begin
        ptr_d      = ptr_q;
      end
`else
      ptr_d       = ptr_q;
`endif
    end
  end

  // State and memory-side registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= {PW{1'b0}};
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      tag_vld_q   <= 1'b0;
      tag_q       <= {PW{1'b0}};
      rvalid_q    <= {NUM_REQ{1'b0}};
    end else begin
      ptr_q       <= ptr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tag_vld_q   <= tag_vld_d;
      tag_q       <= tag_d;
      rvalid_q    <= rvalid_d;
    end
  end

`ifdef BURST_LOCK_EN
  // Lock counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt_q <= {CW{1'b0}};
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end
`endif

  assign bus.gnt            = gnt_s;
  assign bus.rvalid         = rvalid_q;
  assign bus.rdata          = bus.mem_read_data;
  assign bus.mem_clk        = clk;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_write_data = mem_wdata_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Round-robin arbiter that shares the single-port message/output memory (mem_clk/mem_we/mem_addr/mem_write_data/mem_read_data) between NUM_REQ requesters, e.g. several hash cores fetching message words and writing hash results. It accepts at most one access per cycle, drives registered memory-side signals, and returns read data to the originating requester with a fixed latency. It sits between the hash cores and the testbench/system memory.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
AW, 16, address width
DW, 32, data width
MAX_LOCK, 16, maximum consecutive accesses under lock (used only with BURST_LOCK_EN)

Ports:
clk  input  1  clock; also forwarded as mem_clk
reset  input  1  synchronous active-high reset
req  input  NUM_REQ  per-requester access request, held until accepted
req_we  input  NUM_REQ  1=write, 0=read, per requester
req_addr  input  NUM_REQ*AW  flattened addresses, requester i at [i*AW +: AW]
req_wdata  input  NUM_REQ*DW  flattened write data, requester i at [i*DW +: DW]
req_lock  input  NUM_REQ  burst-lock request (ignored without BURST_LOCK_EN)
gnt  output  NUM_REQ  one-hot combinational grant; access accepted at a rising edge where req[i]&gnt[i]
rvalid  output  NUM_REQ  one-hot read-data-valid strobe
rdata  output  DW  read data, equal to mem_read_data, qualified by rvalid
mem_clk  output  1  equal to clk
mem_we  output  1  registered memory write enable
mem_addr  output  AW  registered memory address
mem_write_data  output  DW  registered memory write data
mem_read_data  input  DW  memory read data, valid one cycle after mem_addr is presented

Behaviour:
- Single clock clk, synchronous active-high reset; all state updates on rising clk.
- Reset values: ptr=0, mem_we=0, mem_addr=0, mem_write_data=0, rvalid=0, read-tag pipeline cleared, lock counter 0. gnt=0 while reset is high.
- Arbitration (combinational): if any req, gnt selects the first requester with req set, scanning ptr, ptr+1, ... modulo NUM_REQ; else gnt=0. gnt never has more than one bit set.
- Acceptance at edge E0 (req[i]&gnt[i]):
  - mem_addr<=addr_i; mem_write_data<=wdata_i; mem_we<=req_we[i]; ptr<=(i+1) mod NUM_REQ.
  - A read pushes tag i into a 2-stage pipeline.
- No acceptance at E0: mem_we<=0; mem_addr and mem_write_data hold their values; ptr holds.
- Read timing: acceptance at E0, memory samples address at E1, rvalid[i]=1 and rdata valid in the cycle after E1 (sampled by the requester at E2). Fixed 2-cycle latency; one read may complete every cycle.
- Writes produce no rvalid. A write is committed at E1.
- Back-to-back accesses from different requesters are allowed every cycle. Starvation bound without lock: NUM_REQ-1 cycles.
- A requester may change addr/we/wdata only after acceptance. Dropping req before acceptance is legal; nothing is issued.
- Reset mid-operation: in-flight reads are dropped (no rvalid after reset). mem_we forced 0 the cycle after reset is sampled.

Optional Feature:
Macro BURST_LOCK_EN.
- Defined: when requester i is accepted with req_lock[i]=1, ptr stays at i, so i keeps priority on following cycles.
- A lock counter increments on each locked acceptance. When it reaches MAX_LOCK, or req_lock[i] drops, or i has no req in a cycle, ptr advances to i+1 and the counter clears.
- Not defined: req_lock is ignored and behaviour is pure round-robin.

Test Plan:
- Reset: hold reset 2 cycles with req=4'b1111 -> gnt=0, mem_we=0, mem_addr=0, rvalid=0; after release, first grant goes to requester 0.
- Fairness: req=4'b1111 held 8 cycles, all reads -> gnt sequence 0,1,2,3,0,1,2,3; mem_addr follows each requester's address.
- Read return: requester 2 reads 16'h0010 with memory[16'h0010]=32'hDEADBEEF -> rvalid=4'b0100 exactly 2 cycles after acceptance, rdata=32'hDEADBEEF.
- Write then read: requester 1 writes 32'h12345678 to 16'h0040, then requester 3 reads 16'h0040 -> mem_we high for one cycle; requester 3 receives 32'h12345678; no rvalid for the write.
- Reset mid-read: read accepted, reset asserted at the next edge -> no rvalid ever issued for that read.
- BURST_LOCK_EN with MAX_LOCK=4: requester 0 locked, requester 1 requesting -> 4 consecutive grants to 0, then a grant to 1. Without the macro -> grants alternate 0,1.
